i2c_slave: RTL and testbench
============================

# i2c_slave

Responder end of the team's I2C link: a single-address I2C target that watches `sclk`/`sda_in` driven by the `master` block and answers on `sda_out`. Both I2C lines are sampled into the system clock domain. The block detects START/STOP, matches a 7-bit address and ACKs it. It then either receives bytes into `data_out` or transmits bytes from `data_in`. It sits beside `master` in the top level and in loopback benches.

## Interface
- `ADDR`, 7'h42: 7-bit target address.
- `clk` input 1: system clock. All logic is on its rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `sclk` input 1: I2C clock from the master, asynchronous to `clk`.
- `sda_in` input 1: I2C data line as seen by the slave.
- `sda_out` output 1: slave data drive. 0 pulls the line low; 1 releases it.
- `data_in` input 8: byte to transmit. Sampled when the slave loads it.
- `data_out` output 8: last byte received from the master.
- `data_valid` output 1: one-`clk` pulse when `data_out` updates.
- `data_req` output 1: one-`clk` pulse requesting the next `data_in` byte.
- `busy` output 1: high in any state other than IDLE.
- `state` output 3: current FSM state.

## Operation
- Line front end: 2-flop synchroniser on `sclk` and on `sda_in`, plus previous-value registers.
  - `rise` / `fall` = sclk edges.
  - START = synchronised sda falls while sclk is high.
  - STOP = synchronised sda rises while sclk is high.
- Data bits are sampled on `rise`. `sda_out` changes only on `fall`.
- Bit order is MSB first. The bit counter is 3 bits and wraps 7 to 0.
- States:
  - IDLE=0: wait for START.
  - ADDRESS=1: shift 8 bits (7 address bits, then R/W).
  - ADDR_ACK=2:
    - On address match, drive 0 for one sclk period from the `fall` after bit 8 to the next `fall`.
    - On mismatch, release the line and go to IDLE (ignore traffic until the next START).
  - RECEIVE=3: shift 8 bits.
  - DATA_ACK=4: drive ACK 0 after the 8th bit. At the same `fall` that asserts ACK, load `data_out` and pulse `data_valid`. Return to RECEIVE.
  - TRANSMIT=5: drive `data_in` bits. The byte is loaded into the shift register at the `fall` ending ADDR_ACK (R/W=1), and `data_req` pulses on that same cycle.
  - MASTER_ACK=6: release the line and sample the master's bit on `rise`.
    - Sampled 0: reload `data_in`, pulse `data_req`, go to TRANSMIT.
    - Sampled 1 (NACK): go to IDLE.
- START in any state, including a repeated START, goes to ADDRESS with the bit counter at 0 and `sda_out` = 1. STOP in any state goes to IDLE with `sda_out` = 1.
- Both START and STOP take priority over a `rise`/`fall` detected in the same cycle.
- The block does no clock stretching: `sclk` is never driven.

## Timing
- Reset values: `sda_out`=1, `data_out`=8'h00, `data_valid`=0, `data_req`=0, `busy`=0, `state`=IDLE. The shift register and bit counter also reset to 0.
- Assertion of `rst` mid-transfer releases `sda_out` immediately (asynchronous). After deassertion the slave waits for a fresh START.
- Line-to-event latency is 3 `clk` cycles: 2 sync flops plus the edge register.
- `sda_out` updates 1 `clk` after the `fall` is detected, so it changes at most 4 `clk` cycles after the pin edge.
- Requirements on the master: the sclk high phase and low phase must each last at least 6 `clk` cycles, and sda must be stable for at least 3 `clk` cycles before each sclk `rise`.
- `data_in` must be valid within 1 `clk` of a `data_req` pulse. It is captured 1 `clk` after the pulse.

## Structure
- Shared package `i2c_pkg`:
  - 3-bit state localparams, shared numbering with `master`.
  - ACK=1'b0 and NACK=1'b1 constants.
  - Default address.
- Sub-module `i2c_line_sync`: synchroniser and edge/START/STOP detector. Outputs `scl_rise`, `scl_fall`, `sda_s`, `start`, `stop`. Reusable by `master`.
- Top level: FSM, shift register, bit counter, output registers.

## Test plan
- Write to 0x42 with byte 0xA5: ACK driven low during the 9th clock of both address and data. `data_out`=8'hA5, `data_valid` pulses once. STOP then gives `state`=0 and `busy`=0.
- Write to 0x43 (mismatch): `sda_out` stays 1 throughout, no `data_valid`, `state` returns to IDLE after ADDR_ACK.
- Read from 0x42 with `data_in`=8'hF6: `sda_out` bits are 1,1,1,1,0,1,1,0. A master NACK then gives `state`=IDLE with `sda_out`=1.
- Multi-byte read: master ACKs the first byte (0xF6), `data_req` pulses, and `data_in`=8'h3C is shifted out next. NACK then STOP.
- Two-byte write 0x11, 0x22 followed by a repeated START and a read: `data_valid` pulses twice with the correct values, then `state`=ADDRESS directly without passing through IDLE.
- `rst` driven low in RECEIVE at bit 4: `sda_out`=1 and `state`=0 immediately. Remaining master clocks produce no ACK until a new START.

Source files
------------

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Definitions shared by the I2C blocks (slave and master):
//   - i2c_state_t  : 3-bit FSM state numbering common to both ends of the link
//   - ACK / NACK   : values of the acknowledge bit on the SDA line
//   - DEFAULT_ADDR : default 7-bit target address
//   - addr_match   : compares a received {address, R/W} byte with an address
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADDRESS    = 3'd1,
        ST_ADDR_ACK   = 3'd2,
        ST_RECEIVE    = 3'd3,
        ST_DATA_ACK   = 3'd4,
        ST_TRANSMIT   = 3'd5,
        ST_MASTER_ACK = 3'd6
    } i2c_state_t;

    localparam logic       ACK          = 1'b0;
    localparam logic       NACK         = 1'b1;
    localparam logic [6:0] DEFAULT_ADDR = 7'h42;

    // The address occupies the upper seven bits; bit 0 is R/W.
    function automatic logic addr_match(input logic [7:0] addr_rw, input logic [6:0] own);
        return (addr_rw[7:1] == own);
    endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// -----------------------------------------------------------------------------
// i2c_slave_if
// Bus bundle between the I2C target and whatever drives it.
//   sclk, sda_in        : I2C lines as seen by the slave
//   sda_out             : slave SDA drive (0 = pull low, 1 = release)
//   data_in / data_req  : byte to transmit and its request pulse
//   data_out/data_valid : last received byte and its update pulse
//   busy, state         : FSM status
// Modport slave is used by i2c_slave, modport master by the driving side.
// -----------------------------------------------------------------------------
interface i2c_slave_if;

    logic       sclk;
    logic       sda_in;
    logic       sda_out;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_req;
    logic       busy;
    logic [2:0] state;

    modport slave (
        input  sclk, sda_in, data_in,
        output sda_out, data_out, data_valid, data_req, busy, state
    );

    modport master (
        output sclk, sda_in, data_in,
        input  sda_out, data_out, data_valid, data_req, busy, state
    );

endinterface

// File: rtl/i2c_line_sync.sv
// -----------------------------------------------------------------------------
// i2c_line_sync
// Brings SCL and SDA into the clk domain and decodes bus events.
//   clk, rst  : system clock, asynchronous active-low reset
//   scl, sda  : raw I2C lines (asynchronous to clk)
//   scl_rise  : one-cycle pulse on a synchronised SCL rising edge
//   scl_fall  : one-cycle pulse on a synchronised SCL falling edge
//   sda_s     : synchronised SDA, aligned with the event pulses
//   start     : SDA fell while SCL high
//   stop      : SDA rose while SCL high
// Pin-to-event latency is three clocks (two sync flops + event register).
// -----------------------------------------------------------------------------
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync_r;
    logic [1:0] sda_sync_r;
    logic       scl_prev_r;
    logic       sda_prev_r;

    // Synchroniser chains, previous-value registers and registered event decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Idle bus level is high on both lines.
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
            scl_rise   <= 1'b0;
            scl_fall   <= 1'b0;
            sda_s      <= 1'b1;
            start      <= 1'b0;
            stop       <= 1'b0;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl};
            sda_sync_r <= {sda_sync_r[0], sda};
            scl_prev_r <= scl_sync_r[1];
            sda_prev_r <= sda_sync_r[1];
            scl_rise   <= scl_sync_r[1] & ~scl_prev_r;
            scl_fall   <= ~scl_sync_r[1] & scl_prev_r;
            sda_s      <= sda_sync_r[1];
            // SCL must have been high on both samples so an SCL edge is never
            // mistaken for a START/STOP.
            start      <= scl_sync_r[1] & scl_prev_r & sda_prev_r & ~sda_sync_r[1];
            stop       <= scl_sync_r[1] & scl_prev_r & ~sda_prev_r & sda_sync_r[1];
        end
    end

endmodule

// File: rtl/i2c_slave.sv
// -----------------------------------------------------------------------------
// i2c_slave
// Single-address I2C target. Detects START/STOP, matches a 7-bit address,
// ACKs it, then receives bytes into data_out or transmits bytes from data_in.
// No clock stretching: SCL is only ever observed.
//   ADDR : 7-bit target address
//   clk  : system clock (rising edge)
//   rst  : asynchronous active-low reset
//   bus  : i2c_slave_if.slave (lines, data handshake, status)
// -----------------------------------------------------------------------------
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = DEFAULT_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    i2c_slave_if.slave bus
);

    logic scl_rise_s;
    logic scl_fall_s;
    logic sda_s;
    logic start_s;
    logic stop_s;

    i2c_state_t state_r;
    logic [7:0] shift_r;
    logic [2:0] bit_cnt_r;
    logic       sda_out_r;
    logic [7:0] data_out_r;
    logic       data_valid_r;
    logic       data_req_r;
    logic       busy_r;
    logic       ack_drv_r;     // ACK is currently being driven (second fall ends it)
    logic       load_r;        // capture data_in this cycle (one clk after data_req)
    logic       load_drive_r;  // put bit 7 on the line as soon as it is captured
    logic       tx_first_r;    // next fall drives bit 7 without shifting

    i2c_line_sync u_line_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (bus.sclk),
        .sda      (bus.sda_in),
        .scl_rise (scl_rise_s),
        .scl_fall (scl_fall_s),
        .sda_s    (sda_s),
        .start    (start_s),
        .stop     (stop_s)
    );

    // Protocol FSM: shifting, ACK drive, handshake pulses and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            shift_r      <= 8'h00;
            bit_cnt_r    <= 3'd0;
            sda_out_r    <= NACK;
            data_out_r   <= 8'h00;
            data_valid_r <= 1'b0;
            data_req_r   <= 1'b0;
            busy_r       <= 1'b0;
            ack_drv_r    <= 1'b0;
            load_r       <= 1'b0;
            load_drive_r <= 1'b0;
            tx_first_r   <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            data_req_r   <= 1'b0;
            if (start_s) begin
                // START (also repeated START) restarts address reception.
                state_r      <= ST_ADDRESS;
                bit_cnt_r    <= 3'd0;
                sda_out_r    <= NACK;
                busy_r       <= 1'b1;
                ack_drv_r    <= 1'b0;
                load_r       <= 1'b0;
                load_drive_r <= 1'b0;
                tx_first_r   <= 1'b0;
            end else if (stop_s) begin
                state_r      <= ST_IDLE;
                sda_out_r    <= NACK;
                busy_r       <= 1'b0;
                ack_drv_r    <= 1'b0;
                load_r       <= 1'b0;
                load_drive_r <= 1'b0;
                tx_first_r   <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        busy_r <= 1'b0;
                    end
                    ST_ADDRESS: begin
                        if (scl_rise_s) begin
                            shift_r   <= {shift_r[6:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                state_r <= ST_ADDR_ACK;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_drv_r) begin
                                if (addr_match(shift_r, ADDR)) begin
                                    sda_out_r <= ACK;
                                    ack_drv_r <= 1'b1;
                                end else begin
                                    state_r   <= ST_IDLE;
                                    sda_out_r <= NACK;
                                    busy_r    <= 1'b0;
                                end
                            end else begin
                                ack_drv_r <= 1'b0;
                                bit_cnt_r <= 3'd0;
                                if (shift_r[0]) begin
                                    // Read: request the first byte; the line keeps
                                    // the ACK until the byte is captured next clk.
                                    state_r      <= ST_TRANSMIT;
                                    data_req_r   <= 1'b1;
                                    load_r       <= 1'b1;
                                    load_drive_r <= 1'b1;
                                end else begin
                                    state_r   <= ST_RECEIVE;
                                    sda_out_r <= NACK;
                                end
                            end
                        end
                    end
                    ST_RECEIVE: begin
                        if (scl_rise_s) begin
                            shift_r   <= {shift_r[6:0], sda_s};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                state_r <= ST_DATA_ACK;
                            end
                        end
                    end
                    ST_DATA_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_drv_r) begin
                                data_out_r   <= shift_r;
                                data_valid_r <= 1'b1;
                                sda_out_r    <= ACK;
                                ack_drv_r    <= 1'b1;
                            end else begin
                                ack_drv_r <= 1'b0;
                                sda_out_r <= NACK;
                                state_r   <= ST_RECEIVE;
                            end
                        end
                    end
                    ST_TRANSMIT: begin
                        if (load_r) begin
                            load_r       <= 1'b0;
                            load_drive_r <= 1'b0;
                            shift_r      <= bus.data_in;
                            if (load_drive_r) begin
                                sda_out_r  <= bus.data_in[7];
                                tx_first_r <= 1'b0;
                            end else begin
                                tx_first_r <= 1'b1;
                            end
                        end else if (scl_fall_s) begin
                            if (tx_first_r) begin
                                sda_out_r  <= shift_r[7];
                                tx_first_r <= 1'b0;
                            end else begin
                                shift_r   <= {shift_r[6:0], 1'b0};
                                sda_out_r <= shift_r[6];
                            end
                        end else if (scl_rise_s) begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                state_r <= ST_MASTER_ACK;
                            end
                        end
                    end
                    ST_MASTER_ACK: begin
                        if (scl_fall_s) begin
                            sda_out_r <= NACK;
                        end else if (scl_rise_s) begin
                            if (sda_s == ACK) begin
                                state_r      <= ST_TRANSMIT;
                                bit_cnt_r    <= 3'd0;
                                data_req_r   <= 1'b1;
                                load_r       <= 1'b1;
                                load_drive_r <= 1'b0;
                            end else begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        sda_out_r <= NACK;
                        busy_r    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sda_out    = sda_out_r;
    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.data_req   = data_req_r;
    assign bus.busy       = busy_r;
    assign bus.state      = state_r;

endmodule

// File: tb/tb_i2c_slave.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave
// Bit-banged I2C master driving i2c_slave. Each transfer task pushes the
// expected slave SDA level for every SCL high phase, the expected received
// bytes and the bytes to serve on data_req into queues; independent monitor
// processes pop and compare when the DUT presents the matching output.
// -----------------------------------------------------------------------------
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam logic [6:0] OWN = 7'h42;

    logic clk;
    logic rst;
    logic m_scl;
    logic m_sda;
    logic mon_en;
    logic watch_idle;
    logic saw_idle;

    int n_checks;
    int n_fail;

    logic       exp_sda_q [$];
    logic [7:0] rx_q      [$];
    logic [7:0] tx_q      [$];

    i2c_slave_if bus ();

    // Open-drain wired-AND of master and slave SDA drivers.
    assign bus.sclk   = m_scl;
    assign bus.sda_in = m_sda & bus.sda_out;

    i2c_slave #(.ADDR(OWN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL pulse with the master driving drv; exp is the slave's SDA during high.
    task automatic clock_bit(input logic drv, input logic exp);
        m_sda = drv;
        wait_clk(8);
        exp_sda_q.push_back(exp);
        m_scl = 1'b1;
        wait_clk(8);
        m_scl = 1'b0;
        wait_clk(2);
    endtask

    task automatic i2c_start();
        if (m_scl == 1'b0) begin
            m_sda = 1'b1;
            wait_clk(8);
            exp_sda_q.push_back(1'b1);
            m_scl = 1'b1;
            wait_clk(8);
        end
        m_sda = 1'b0;
        wait_clk(8);
        m_scl = 1'b0;
        wait_clk(2);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        wait_clk(8);
        exp_sda_q.push_back(1'b1);
        m_scl = 1'b1;
        wait_clk(8);
        m_sda = 1'b1;
        wait_clk(8);
    endtask

    // Write: the addressed target ACKs the address and every byte; others stay silent.
    task automatic write_xfer(input bit do_start, input logic [6:0] addr,
                              input logic [31:0] data, input int n);
        logic [7:0] a;
        logic [7:0] b;
        bit         hit;
        hit = (addr == OWN);
        a   = {addr, 1'b0};
        if (do_start) i2c_start();
        for (int i = 0; i < 8; i++) clock_bit(a[7-i], 1'b1);
        clock_bit(1'b1, hit ? 1'b0 : 1'b1);
        for (int k = 0; k < n; k++) begin
            b = data[31-8*k -: 8];
            if (hit) rx_q.push_back(b);
            for (int i = 0; i < 8; i++) clock_bit(b[7-i], 1'b1);
            clock_bit(1'b1, hit ? 1'b0 : 1'b1);
        end
    endtask

    // Read from the own address: slave drives each byte MSB first, master ACKs
    // all but the last byte, which it NACKs.
    task automatic read_xfer(input bit do_start, input logic [31:0] data, input int n);
        logic [7:0] a;
        logic [7:0] b;
        a = {OWN, 1'b1};
        for (int k = 0; k < n; k++) tx_q.push_back(data[31-8*k -: 8]);
        if (do_start) i2c_start();
        for (int i = 0; i < 8; i++) clock_bit(a[7-i], 1'b1);
        clock_bit(1'b1, 1'b0);
        for (int k = 0; k < n; k++) begin
            b = data[31-8*k -: 8];
            for (int i = 0; i < 8; i++) clock_bit(1'b1, b[7-i]);
            clock_bit((k == n - 1) ? 1'b1 : 1'b0, 1'b1);
        end
    endtask

    // Monitor: slave SDA level in the middle of every SCL high phase.
    initial begin
        forever begin
            @(posedge m_scl);
            if (mon_en) begin
                wait_clk(4);
                if (exp_sda_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sda_out: SCL pulse with no expectation at %0t", $time);
                end else begin
                    chk("sda_out", {31'd0, bus.sda_out}, {31'd0, exp_sda_q.pop_front()});
                end
            end
        end
    end

    // Monitor: received bytes.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.data_valid === 1'b1) begin
                if (rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL data_valid: unexpected pulse, data_out %0h at %0t", bus.data_out, $time);
                end else begin
                    chk("data_out", {24'd0, bus.data_out}, {24'd0, rx_q.pop_front()});
                end
            end
        end
    end

    // Responder: serves the next queued byte whenever data_req pulses.
    initial begin
        bus.data_in = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.data_req === 1'b1) begin
                chk("data_req_pending", {31'd0, (tx_q.size() != 0)}, 32'd1);
                if (tx_q.size() != 0) bus.data_in = tx_q.pop_front();
            end
        end
    end

    // Flags any visit to IDLE while watching a repeated START.
    initial begin
        saw_idle = 1'b0;
        forever begin
            @(negedge clk);
            if (!watch_idle) saw_idle = 1'b0;
            else if (bus.state == 3'd0) saw_idle = 1'b1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  ra;
        logic [31:0] rd;
        int          rn;
        n_checks   = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        watch_idle = 1'b0;
        m_scl      = 1'b1;
        m_sda      = 1'b1;
        rst        = 1'b0;
        wait_clk(4);

        // Reset values.
        chk("rst_sda_out",    {31'd0, bus.sda_out},    32'd1);
        chk("rst_data_out",   {24'd0, bus.data_out},   32'h00);
        chk("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("rst_data_req",   {31'd0, bus.data_req},   32'd0);
        chk("rst_busy",       {31'd0, bus.busy},       32'd0);
        chk("rst_state",      {29'd0, bus.state},      32'd0);
        rst = 1'b1;
        wait_clk(4);
        mon_en = 1'b1;

        // Write 0xA5 to own address.
        write_xfer(1'b1, OWN, 32'hA500_0000, 1);
        chk("write_busy", {31'd0, bus.busy}, 32'd1);
        i2c_stop();
        chk("stop_state", {29'd0, bus.state}, 32'd0);
        chk("stop_busy",  {31'd0, bus.busy},  32'd0);

        // Write to a foreign address.
        write_xfer(1'b1, 7'h43, 32'h5A00_0000, 1);
        chk("mismatch_state", {29'd0, bus.state}, 32'd0);
        i2c_stop();

        // Single-byte read, NACKed.
        read_xfer(1'b1, 32'hF600_0000, 1);
        chk("nack_state",   {29'd0, bus.state},   32'd0);
        chk("nack_sda_out", {31'd0, bus.sda_out}, 32'd1);
        i2c_stop();

        // Two-byte read.
        read_xfer(1'b1, 32'hF63C_0000, 2);
        i2c_stop();

        // Two-byte write, repeated START, then read.
        write_xfer(1'b1, OWN, 32'h1122_0000, 2);
        watch_idle = 1'b1;
        i2c_start();
        chk("rstart_state",    {29'd0, bus.state}, 32'd1);
        chk("rstart_no_idle",  {31'd0, saw_idle},  32'd0);
        watch_idle = 1'b0;
        read_xfer(1'b0, 32'h9D00_0000, 1);
        i2c_stop();

        // Reset in RECEIVE after four data bits.
        write_xfer(1'b1, OWN, 32'h0, 0);
        for (int i = 0; i < 4; i++) clock_bit(1'b0, 1'b1);
        chk("pre_rst_state", {29'd0, bus.state}, 32'd3);
        rst = 1'b0;
        #1;
        chk("async_rst_sda_out", {31'd0, bus.sda_out}, 32'd1);
        chk("async_rst_state",   {29'd0, bus.state},   32'd0);
        wait_clk(3);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) clock_bit(1'b1, 1'b1);
        clock_bit(1'b1, 1'b1);
        chk("post_rst_state", {29'd0, bus.state}, 32'd0);
        i2c_stop();

        // Randomised transfers.
        for (int t = 0; t < 8; t++) begin
            rn = int'($urandom_range(3, 1));
            rd = $urandom;
            if ($urandom_range(1, 0) == 1) begin
                read_xfer(1'b1, rd, rn);
            end else begin
                ra = ($urandom_range(1, 0) == 1) ? OWN : 7'(($urandom_range(126, 67)));
                write_xfer(1'b1, ra, rd, rn);
            end
            i2c_stop();
            chk("rand_idle", {29'd0, bus.state}, 32'd0);
        end

        wait_clk(10);
        chk("sda_q_drained", exp_sda_q.size(), 32'd0);
        chk("rx_q_drained",  rx_q.size(),      32'd0);
        chk("tx_q_drained",  tx_q.size(),      32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
